// File: rtl/vga_line_fetch.sv
// vga_line_fetch: prefetches scan lines into a ping-pong buffer and serves pixel colours with a fixed 2-cycle latency
module vga_line_fetch #(
  parameter logic [15:0] FB_BASE = 16'h0000,
  parameter int WORDS_PER_LINE = 128,
  parameter int LAST_LINE = 479
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [8:0]  line,
  input  logic [9:0]  offset,
  output logic        r,
  output logic        g,
  output logic        b,
  output logic [15:0] mem_addr,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        busy,
  output logic        underrun
);
  localparam int CW = WORDS_PER_LINE > 1 ? $clog2(WORDS_PER_LINE) : 1;
  localparam int AW = $clog2(2 * WORDS_PER_LINE);
  localparam logic [CW-1:0] CMAX = CW'(WORDS_PER_LINE - 1);
  localparam logic [15:0] WPL16 = 16'(WORDS_PER_LINE);
  localparam logic [9:0] WPL10 = 10'(WORDS_PER_LINE);
  localparam logic [AW-1:0] BANK1 = AW'(WORDS_PER_LINE);
  localparam logic [8:0] LAST = 9'(LAST_LINE);
  typedef enum logic [1:0] {IDLE, REQ, DONE_CHK} state_t;
  state_t state, state_nxt;
  logic [8:0] prev_line, pend_line, want_line, tgt, tgt_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic pend, evt, want, consume, second, second_nxt, wr_en;
  logic [14:0] lbuf [2*WORDS_PER_LINE];
  logic [14:0] rd_word;
  logic [AW-1:0] wa, ra;
  logic [9:0] widx;
  logic [2:0] slot, rd_slot, pix;
  logic oob, rd_oob;
  logic unused_bit;
  assign unused_bit = mem_rdata[15];
  assign evt = line != prev_line;
  assign want = evt | pend;
  assign want_line = evt ? line : pend_line;
  assign busy = state != IDLE;
  assign mem_req = state == REQ;
  assign mem_addr = FB_BASE + 16'(tgt) * WPL16 + 16'(cnt);
  assign wa = tgt[0] ? BANK1 + AW'(cnt) : AW'(cnt);
  assign widx = offset / 10'd5;
  assign slot = 3'(offset % 10'd5);
  assign oob = offset >= 10'd640 || widx >= WPL10;
  assign ra = (line[0] ? BANK1 : '0) + (oob ? '0 : AW'(widx));
  assign pix = rd_slot == 3'd0 ? rd_word[2:0] : rd_slot == 3'd1 ? rd_word[5:3] :
               rd_slot == 3'd2 ? rd_word[8:6] : rd_slot == 3'd3 ? rd_word[11:9] : rd_word[14:12];
  // fetch sequencer: latest line event wins, a pending event ends the current fetch at its next ack
  always_comb begin
    state_nxt = state;
    tgt_nxt = tgt;
    cnt_nxt = cnt;
    second_nxt = second;
    wr_en = 1'b0;
    consume = 1'b0;
    unique case (state)
      IDLE: if (want) begin
        consume = 1'b1;
        if (want_line < LAST) begin
          state_nxt = REQ;
          tgt_nxt = want_line == 9'd0 ? 9'd0 : want_line + 9'd1;
          cnt_nxt = '0;
          second_nxt = want_line == 9'd0;
        end
      end
      REQ: if (mem_ack) begin
        wr_en = 1'b1;
        if (want) state_nxt = IDLE;
        else if (cnt == CMAX) state_nxt = DONE_CHK;
        else cnt_nxt = cnt + 1'b1;
      end
      DONE_CHK: if (want) state_nxt = IDLE;
      else if (second) begin
        second_nxt = 1'b0;
        tgt_nxt = 9'd1;
        cnt_nxt = '0;
        state_nxt = REQ;
      end else state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // control state; reset posts a line-0 event so the frame-start fetch begins right away
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      prev_line <= '0;
      pend <= 1'b1;
      pend_line <= '0;
      tgt <= '0;
      cnt <= '0;
      second <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state <= state_nxt;
      prev_line <= line;
      pend <= consume ? 1'b0 : want;
      pend_line <= want_line;
      tgt <= tgt_nxt;
      cnt <= cnt_nxt;
      second <= second_nxt;
      if (evt && state != IDLE) underrun <= 1'b1;
    end
  end
  // line buffer: write from memory, registered read for the display side
  always_ff @(posedge clk) begin
    if (wr_en) lbuf[wa] <= mem_rdata[14:0];
    rd_word <= lbuf[ra];
  end
  // pixel slot select and output register
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_slot <= '0;
      rd_oob <= 1'b1;
      {r, g, b} <= 3'b000;
    end else begin
      rd_slot <= slot;
      rd_oob <= oob;
      {r, g, b} <= rd_oob ? 3'b000 : pix;
    end
  end
endmodule

// File: tb/tb_vga_line_fetch.sv
// tb_vga_line_fetch: directed read vectors plus fetch, underrun and reset sequences
module tb_vga_line_fetch;
  logic clk = 0, reset = 1;
  logic [8:0] line = 0;
  logic [9:0] offset = 0;
  logic r, g, b, mem_req, busy, underrun;
  logic mem_ack = 0;
  logic [15:0] mem_addr, mem_rdata = 0;
  int total = 0, bad = 0, ack_every = 1, wc = 0;
  bit stray = 0;
  logic [15:0] alog[$];

  vga_line_fetch dut (.clk(clk), .reset(reset), .line(line), .offset(offset), .r(r), .g(g), .b(b),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .underrun(underrun));

  always #5 clk = ~clk;

  function automatic logic [15:0] word_at(input logic [15:0] a);
    case (a)
      16'd0:   return 16'h7AC5;
      16'd1:   return 16'h0140;
      16'd127: return 16'h0007;
      16'd128: return 16'h7FFF;
      16'd129: return 16'h0006;
      16'd255: return 16'h3000;
      16'd256: return 16'h0038;
      default: return 16'h8000;
    endcase
  endfunction

  always @(negedge clk) begin
    mem_rdata = word_at(mem_addr);
    if (stray) mem_ack = 1;
    else if (mem_req) begin
      if (wc >= ack_every - 1) begin
        mem_ack = 1;
        wc = 0;
        alog.push_back(mem_addr);
      end else begin
        mem_ack = 0;
        wc++;
      end
    end else begin
      mem_ack = 0;
      wc = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 3000) begin
      tick();
      n++;
    end
    chk(nm, busy, 0);
  endtask

  task automatic chk_sweep(input string nm, input int base, input int len);
    int errs = 0;
    for (int i = 0; i < alog.size(); i++) if (alog[i] != 16'(base + i)) errs++;
    chk({nm, "_len"}, alog.size(), len);
    chk({nm, "_order"}, errs, 0);
  endtask

  typedef struct {
    logic [8:0] ln;
    logic [9:0] off;
    logic [2:0] rgb;
  } vec_t;
  vec_t tv[16];

  initial begin
    int n, a, n0, reqs;
    tv[0] = '{0, 0, 3'b101};    tv[1] = '{0, 1, 3'b000};
    tv[2] = '{0, 2, 3'b011};    tv[3] = '{0, 3, 3'b101};
    tv[4] = '{0, 4, 3'b111};    tv[5] = '{0, 7, 3'b101};
    tv[6] = '{0, 635, 3'b111};  tv[7] = '{0, 639, 3'b000};
    tv[8] = '{0, 640, 3'b000};  tv[9] = '{0, 799, 3'b000};
    tv[10] = '{0, 12, 3'b000};  tv[11] = '{1, 639, 3'b011};
    tv[12] = '{1, 5, 3'b110};   tv[13] = '{1, 0, 3'b111};
    tv[14] = '{1, 640, 3'b000}; tv[15] = '{1, 700, 3'b000};
    tick();
    tick();
    chk("rst_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", mem_addr, 16'h0000);
    chk("rst_urun", underrun, 0);
    chk("rst_rgb", {r, g, b}, 3'b000);
    reset = 0;
    n = 0;
    for (int k = 0; k < 2000; k++) begin
      tick();
      if (k == 0) chk("busy_rise", busy, 1);
      if (!busy) break;
      n++;
    end
    chk("busy_len", n, 258);
    chk_sweep("sweep0", 0, 256);
    chk("urun0", underrun, 0);
    alog.delete();
    foreach (tv[i]) begin
      line = tv[i].ln;
      offset = tv[i].off;
      tick();
      tick();
      chk($sformatf("rd%0d_l%0d_o%0d", i, tv[i].ln, tv[i].off), {r, g, b}, tv[i].rgb);
    end
    wait_idle("idle_l1");
    chk_sweep("sweep2", 256, 128);
    line = 2;
    offset = 1;
    tick();
    tick();
    chk("l2_o1", {r, g, b}, 3'b111);
    offset = 0;
    tick();
    tick();
    chk("l2_o0", {r, g, b}, 3'b000);
    wait_idle("idle_l2");
    ack_every = 8;
    line = 3;
    tick();
    chk("slow_busy", busy, 1);
    repeat (800) tick();
    chk("slow_no_urun", underrun, 0);
    chk("slow_req", mem_req, 1);
    a = mem_addr;
    n0 = alog.size();
    line = 4;
    tick();
    chk("urun_set", underrun, 1);
    for (int k = 0; k < 40; k++) begin
      if (mem_req && mem_addr != 16'(a)) break;
      tick();
    end
    chk("restart_addr", mem_addr, 16'd640);
    chk("old_ack", alog.size() > n0 ? alog[n0] : 16'hFFFF, 16'(a));
    ack_every = 1;
    wait_idle("idle_l4");
    chk("urun_sticky", underrun, 1);
    line = 478;
    tick();
    wait_idle("idle_l478");
    line = 479;
    reqs = 0;
    repeat (20) begin
      tick();
      if (mem_req || busy) reqs++;
    end
    chk("last_noreq", reqs, 0);
    line = 479;
    offset = 650;
    tick();
    tick();
    chk("l479_oob", {r, g, b}, 3'b000);
    ack_every = 50;
    line = 10;
    repeat (3) tick();
    chk("mid_req", mem_req, 1);
    reset = 1;
    line = 0;
    stray = 1;
    tick();
    chk("mid_rst_req", mem_req, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_addr", mem_addr, 16'h0000);
    chk("mid_rst_urun", underrun, 0);
    tick();
    stray = 0;
    ack_every = 1;
    alog.delete();
    reset = 0;
    tick();
    chk("rerun_busy", busy, 1);
    wait_idle("idle_rerun");
    chk_sweep("sweep_rerun", 0, 256);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
